queue_ctrl: RTL and testbench
=============================

// Module: queue_ctrl
// PURPOSE
//   Control unit for the register-based queue: owns head/tail pointers and the occupancy count.
//   Drives one-hot write enables into the DEPTH storage registers.
//   Drives the read select of the 2:1 mux tree that picks the head entry for output.
//   Stores no data itself; the storage registers and mux tree sit beside it in the queue top.
// PARAMETERS
//   DEPTH   8   number of storage slots; power of two, >= 2
//   ADDR_W  3   pointer width, = log2(DEPTH)
// PORTS
//   clk_i        in   1         single clock, rising edge
//   rst_i        in   1         synchronous, active-high reset
//   push_i       in   1         request to enqueue the word on the storage data bus this cycle
//   pop_i        in   1         request to dequeue the head word this cycle
//   wr_en_o      out  DEPTH     one-hot write enable to storage slot [tail]; all-zero if push not accepted
//   rd_sel_o     out  ADDR_W    head pointer; select bits for the read mux tree (MSB = last stage)
//   push_ok_o    out  1         push accepted this cycle (combinational)
//   pop_ok_o     out  1         pop accepted this cycle (combinational)
//   empty_o      out  1         count == 0
//   full_o       out  1         count == DEPTH
//   count_o      out  ADDR_W+1  current occupancy, 0..DEPTH
//   ovf_o        out  1         sticky: push requested while full and not popping
//   udf_o        out  1         sticky: pop requested while empty
// BEHAVIOUR
//   Reset (rst_i high at a rising edge):
//     head=0, tail=0, count=0, ovf_o=0, udf_o=0.
//     Hence empty_o=1, full_o=0, rd_sel_o=0.
//     While rst_i is high, wr_en_o=0, push_ok_o=0 and pop_ok_o=0 (gated combinationally).
//     Reset mid-operation discards all contents; storage registers are not cleared.
//   Acceptance (combinational from current state + requests):
//     pop_ok  = pop_i  & !empty
//     push_ok = push_i & (!full | pop_i)
//   Full with push_i & pop_i:
//     Both are accepted. The head word is read through the mux this cycle; the new word lands in the same slot at the edge.
//   Empty with push_i & pop_i:
//     Push is accepted, pop is rejected, and udf_o is set. The new word is not bypassed to the output.
//   wr_en_o = push_ok ? (1 << tail) : 0. At most one bit is ever high.
//   Clock edge (when not in reset):
//     tail  <= tail + push_ok  (mod DEPTH, natural wrap DEPTH-1 -> 0)
//     head  <= head + pop_ok   (mod DEPTH)
//     count <= count + push_ok - pop_ok; count stays in 0..DEPTH, and on simultaneous accept it is unchanged.
//     ovf_o <= ovf_o | (push_i & full & !pop_i)
//     udf_o <= udf_o | (pop_i & empty)
//   Rejected requests change no state other than the sticky flags. Only reset clears the flags.
//   Latency:
//     A word pushed at edge N is visible on the mux output from cycle N+1, when it is the head.
//     rd_sel_o changes only at clock edges and is glitch-free to the mux tree.
//   Full/empty come from count, not from pointer compare, so head==tail is unambiguous.
//   All outputs other than wr_en_o/push_ok_o/pop_ok_o are registered or decoded from registers only.
// TESTING
//   1. Reset, then idle 3 cycles -> empty_o=1, full_o=0, count_o=0, rd_sel_o=0, wr_en_o=0, ovf_o=udf_o=0.
//   2. 8 pushes, then 1 more -> wr_en_o walks 0x01..0x80, full_o=1, count_o=8.
//      9th push: push_ok_o=0, ovf_o=1 and stays 1.
//   3. From full, 8 pops -> rd_sel_o steps 0..7, queue returns the pushed data in FIFO order, ends with empty_o=1.
//      A 9th pop sets udf_o=1.
//   4. Wrap: push 5, pop 5, push 6 -> wr_en_o for the second batch is 0x20,0x40,0x80,0x01,0x02,0x04.
//      Popped data is in order and count_o=6.
//   5. Simultaneous push+pop: when full, count_o stays 8 and the old head word is output.
//      When empty, push is accepted, pop_ok_o=0, count_o=1 and udf_o=1.
//   6. Assert rst_i with count_o=5 and push_i=1 -> wr_en_o=0 that cycle; the next cycle shows empty_o=1, pointers 0 and flags cleared.

Source files
------------

// File: rtl/queue_ctrl.sv
// ---------------------------------------------------------------------------
// queue_ctrl
//   Control unit for a register-based queue. Owns the head and tail pointers
//   and the occupancy count; drives one-hot write enables into the DEPTH
//   storage registers and the read select of the head-entry mux tree. No data
//   passes through this block.
//
// Parameters
//   DEPTH   number of storage slots (power of two, >= 2)
//   ADDR_W  pointer width, log2(DEPTH)
//
// Ports
//   clk_i      in   1         rising-edge clock
//   rst_i      in   1         synchronous active-high reset
//   push_i     in   1         enqueue request
//   pop_i      in   1         dequeue request
//   wr_en_o    out  DEPTH     one-hot write enable to slot [tail]
//   rd_sel_o   out  ADDR_W    head pointer, read mux select
//   push_ok_o  out  1         push accepted this cycle
//   pop_ok_o   out  1         pop accepted this cycle
//   empty_o    out  1         count == 0
//   full_o     out  1         count == DEPTH
//   count_o    out  ADDR_W+1  occupancy 0..DEPTH
//   ovf_o      out  1         sticky overflow (push while full, no pop)
//   udf_o      out  1         sticky underflow (pop while empty)
// ---------------------------------------------------------------------------
module queue_ctrl #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic              pop_i,
  output logic [DEPTH-1:0]  wr_en_o,
  output logic [ADDR_W-1:0] rd_sel_o,
  output logic              push_ok_o,
  output logic              pop_ok_o,
  output logic              empty_o,
  output logic              full_o,
  output logic [ADDR_W:0]   count_o,
  output logic              ovf_o,
  output logic              udf_o
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

  logic [ADDR_W-1:0] head;
  logic [ADDR_W-1:0] tail;
  logic [ADDR_W:0]   count;
  logic              ovf;
  logic              udf;
  logic              empty;
  logic              full;
  logic              push_ok;
  logic              pop_ok;

  // Full/empty come from the count so head == tail never needs disambiguation.
  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);

  // Acceptance is gated by reset so no slot is written during a reset cycle.
  // A push into a full queue is allowed when a pop frees the head slot in the
  // same cycle: the head is read through the mux before the edge overwrites it.
  assign pop_ok  = !rst_i && pop_i && !empty;
  assign push_ok = !rst_i && push_i && (!full || pop_i);

  always_comb begin
    wr_en_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      wr_en_o[i] = push_ok && (tail == ADDR_W'(i));
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      ovf   <= 1'b0;
      udf   <= 1'b0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      tail  <= tail + ADDR_W'(push_ok);
      head  <= head + ADDR_W'(pop_ok);
      count <= count + (ADDR_W + 1)'(push_ok) - (ADDR_W + 1)'(pop_ok);
      ovf   <= ovf | (push_i && full && !pop_i);
      udf   <= udf | (pop_i && empty);
    end
  end

  assign rd_sel_o  = head;
  assign push_ok_o = push_ok;
  assign pop_ok_o  = pop_ok;
  assign empty_o   = empty;
  assign full_o    = full;
  assign count_o   = count;
  assign ovf_o     = ovf;
  assign udf_o     = udf;

endmodule

// File: tb/tb_queue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_queue_ctrl
//   Directed and randomized bench for queue_ctrl. The bench holds its own copy
//   of the storage registers (written through wr_en_o, read through rd_sel_o)
//   and a reference queue of data words with a head index and sticky flags.
// ---------------------------------------------------------------------------
module tb_queue_ctrl;

  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;

  logic              clk;
  logic              rst_i;
  logic              push_i;
  logic              pop_i;
  logic [DEPTH-1:0]  wr_en_o;
  logic [ADDR_W-1:0] rd_sel_o;
  logic              push_ok_o;
  logic              pop_ok_o;
  logic              empty_o;
  logic              full_o;
  logic [ADDR_W:0]   count_o;
  logic              ovf_o;
  logic              udf_o;

  queue_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .push_i    (push_i),
    .pop_i     (pop_i),
    .wr_en_o   (wr_en_o),
    .rd_sel_o  (rd_sel_o),
    .push_ok_o (push_ok_o),
    .pop_ok_o  (pop_ok_o),
    .empty_o   (empty_o),
    .full_o    (full_o),
    .count_o   (count_o),
    .ovf_o     (ovf_o),
    .udf_o     (udf_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model
  logic [15:0] q[$];
  int          hd;
  bit          m_ovf;
  bit          m_udf;
  logic [15:0] mem [DEPTH];

  int nvec = 0;
  int nerr = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at negedge, check pre-edge outputs, update model at posedge.
  task automatic step(input logic rs, input logic pu, input logic po);
    int               cnt;
    logic             e_push;
    logic             e_pop;
    logic [DEPTH-1:0] e_wr;
    logic [DEPTH-1:0] wr;
    logic [15:0]      d;
    @(negedge clk);
    rst_i  = rs;
    push_i = pu;
    pop_i  = po;
    d      = 16'($urandom);
    #1;
    cnt    = q.size();
    e_pop  = !rs && po && (cnt != 0);
    e_push = !rs && pu && ((cnt != DEPTH) || po);
    e_wr   = '0;
    if (e_push) e_wr[(hd + cnt) % DEPTH] = 1'b1;
    check("push_ok", 32'(push_ok_o), 32'(e_push));
    check("pop_ok",  32'(pop_ok_o),  32'(e_pop));
    check("wr_en",   32'(wr_en_o),   32'(e_wr));
    check("rd_sel",  32'(rd_sel_o),  32'(hd));
    check("count",   32'(count_o),   32'(cnt));
    check("empty",   32'(empty_o),   32'(cnt == 0));
    check("full",    32'(full_o),    32'(cnt == DEPTH));
    check("ovf",     32'(ovf_o),     32'(m_ovf));
    check("udf",     32'(udf_o),     32'(m_udf));
    if (e_pop) check("head_data", 32'(mem[rd_sel_o]), 32'(q[0]));
    wr = wr_en_o;
    @(posedge clk);
    for (int i = 0; i < DEPTH; i++) if (wr[i]) mem[i] = d;
    if (rs) begin
      q.delete();
      hd    = 0;
      m_ovf = 0;
      m_udf = 0;
    end else begin
      if (pu && cnt == DEPTH && !po) m_ovf = 1;
      if (po && cnt == 0) m_udf = 1;
      if (e_pop) begin
        void'(q.pop_front());
        hd = (hd + 1) % DEPTH;
      end
      if (e_push) q.push_back(d);
    end
  endtask

  initial begin
    rst_i  = 1'b1;
    push_i = 1'b0;
    pop_i  = 1'b0;
    hd     = 0;
    m_ovf  = 0;
    m_udf  = 0;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;

    // Reset then idle
    @(posedge clk);
    step(1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0);
    #2;
    check("t1_empty", 32'(empty_o), 32'd1);
    check("t1_count", 32'(count_o), 32'd0);

    // Fill, then one push too many
    for (int i = 0; i < 8; i++) step(0, 1, 0);
    #2;
    check("t2_full", 32'(full_o), 32'd1);
    check("t2_count", 32'(count_o), 32'd8);
    step(0, 1, 0);
    step(0, 0, 0);
    #2;
    check("t2_ovf_sticky", 32'(ovf_o), 32'd1);

    // Drain, then one pop too many
    for (int i = 0; i < 8; i++) step(0, 0, 1);
    #2;
    check("t3_empty", 32'(empty_o), 32'd1);
    step(0, 0, 1);
    step(0, 0, 0);
    #2;
    check("t3_udf", 32'(udf_o), 32'd1);

    // Wrap: push 5, pop 5, push 6
    step(1, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 1);
    for (int i = 0; i < 6; i++) step(0, 1, 0);
    #2;
    check("t4_count", 32'(count_o), 32'd6);
    for (int i = 0; i < 6; i++) step(0, 0, 1);

    // Simultaneous push+pop when full
    for (int i = 0; i < 8; i++) step(0, 1, 0);
    step(0, 1, 1);
    step(0, 1, 1);
    #2;
    check("t5_full_count", 32'(count_o), 32'd8);
    for (int i = 0; i < 8; i++) step(0, 0, 1);

    // Simultaneous push+pop when empty
    step(1, 0, 0);
    step(0, 1, 1);
    #2;
    check("t5_empty_count", 32'(count_o), 32'd1);
    check("t5_empty_udf", 32'(udf_o), 32'd1);
    step(0, 0, 1);

    // Reset mid-operation with a push pending
    step(1, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 0);
    step(1, 1, 0);
    step(0, 0, 0);
    #2;
    check("t6_empty", 32'(empty_o), 32'd1);
    check("t6_rd_sel", 32'(rd_sel_o), 32'd0);

    // Randomized traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 59) == 0), 1'($urandom), 1'($urandom));
    end
    step(0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
